ysyx_22050612_mdu: RTL and testbench
====================================

# ysyx_22050612_mdu

Iterative RV64M multiply/divide unit sitting beside the single-cycle adder path in the execute stage. It accepts one operation through a valid/ready handshake, computes it over multiple cycles with a radix-2 shift-add multiplier or restoring divider, and holds the result until the writeback side takes it. The width is parametrised; `W` word ops are supported when XLEN is 64.

## Interface
- `XLEN`, 64: datapath width; only 32 or 64 are legal.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `flush`  in  1  synchronous abort; the current operation is dropped.
- `in_valid`  in  1  the source is presenting an operation.
- `in_ready`  out  1  the unit can accept an operation; it equals state==IDLE.
- `op`  in  4  operation code, as listed in the package.
- `src1`, `src2`  in  XLEN  operands; rs1 is the multiplicand or dividend.
- `out_valid`  out  1  `result` is valid.
- `out_ready`  in  1  the sink accepts the result.
- `result`  out  XLEN  result of the operation.

## Operation
- **Op codes:** 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU, 8 MULW, C DIVW, D DIVUW, E REMW, F REMUW.
- **Illegal codes:** 9, A and B return 0 with latency 1.
- **XLEN=32:** W codes behave as their base op.
- **Operand latching:** operands are latched at acceptance (`in_valid && in_ready`). Inputs are ignored after that.
- **Multiply:**
  - Multiply the magnitudes; MULHSU treats `src2` as unsigned.
  - Form a 2·XLEN product and negate it if the signs differ.
  - MUL returns the low half; MULH* return the high half.
- **Divide:**
  - Restoring division on magnitudes.
  - The quotient is negated if the signs differ.
  - The remainder takes the dividend's sign.
- **W ops:** use the low 32 bits of each operand, sign- or zero-extended per the signedness of the op. The 32-bit result is sign-extended to XLEN.
- **Divide special cases** are decided at acceptance and bypass CALC:
  - Divisor 0: quotient is all ones, remainder is the dividend (32-bit sign-extended for W).
  - Signed overflow (most-negative ÷ −1): quotient is the dividend, remainder is 0.
- **FSM states:** IDLE, CALC, DONE.
  - IDLE → CALC on acceptance, or IDLE → DONE for a special case or illegal op.
  - CALC → DONE after N iterations. N is XLEN, or 32 for W ops.
  - DONE → IDLE when `out_ready`.
- **Iteration counter:** width clog2(XLEN)+1. It counts from 0 to N−1 and is cleared on acceptance.

## Timing
- **Reset values:**
  - state IDLE, so `in_ready` is 1 even while reset is asserted; sources must not drive `in_valid` during reset.
  - `out_valid` 0.
  - `result` 0.
  - The counter and internal registers are 0.
- **Accept:** acceptance happens at edge E0.
  - Normal op: `out_valid` rises after edge E0+N, giving a latency of N cycles (64, or 32 for W).
  - Special-case or illegal op: `out_valid` rises after E0, giving a latency of 1 cycle.
- **Output hold:** `result` and `out_valid` are held stable while `out_ready` is 0.
  - `out_valid` drops at the edge where `out_ready` is 1.
  - `in_ready` rises in the following cycle; there is no same-cycle re-accept.
- **Flush:** the state returns to IDLE and `out_valid` is 0 at the next edge.
  - `flush` has priority over `in_valid`: nothing is accepted in a cycle where `flush` is high.
  - `flush` in DONE discards the result.
- **Reset mid-operation:** returns to the reset state immediately; no result is produced.

## Structure
- **Package `ysyx_22050612_mdu_pkg`:**
  - Op-code localparams.
  - State enum.
  - Helpers: `is_div`, `is_signed_src1`, `is_signed_src2`, `is_word`, `wants_high`/`wants_rem`.
- **Sub-module `ysyx_22050612_mdu_div`:**
  - One restoring-division step: remainder/quotient shift, trial subtract, restore.
  - Instantiated once and used combinationally each CALC cycle.
- **Top level:** FSM, operand conditioning, shift-add multiply step, sign fix-up and W sign extension.

## Test plan
1. MUL with `src1`=0xFFFFFFFFFFFFFFFF (−1), `src2`=5 → `result`=0xFFFFFFFFFFFFFFFB, `out_valid` 64 cycles after accept.
2. MULHU with `src1`=`src2`=0xFFFFFFFFFFFFFFFF → 0xFFFFFFFFFFFFFFFE. MULHSU with −1 × 2 → 0xFFFFFFFFFFFFFFFF.
3. DIV −7 ÷ 2 → −3. REM −7 ÷ 2 → −1 (0xFFFFFFFFFFFFFFFF). DIVW with `src1`=0x00000000_80000000, `src2`=0xFFFFFFFF → 0xFFFFFFFF80000000, latency 1 (overflow path).
4. DIVU x ÷ 0 → all ones. REMU 0x1234 ÷ 0 → 0x1234. Both have latency 1.
5. Hold `out_ready`=0 for 10 cycles after `out_valid` → `result` stable and `in_ready` 0. Then assert `out_ready` → `in_ready`=1 on the next cycle.
6. `flush` in CALC cycle 20, with `in_valid` high in the same cycle → no `out_valid` and no accept, state IDLE next cycle. Then assert `rst_n`=0 mid-CALC → `out_valid`=0 and `result`=0 immediately.

Source files
------------

// File: rtl/ysyx_22050612_mdu_pkg.sv
// Shared op codes, FSM state type and op-decode helpers for the iterative
// RV64M multiply/divide unit.
package ysyx_22050612_mdu_pkg;

    localparam logic [3:0] OP_MUL    = 4'h0;
    localparam logic [3:0] OP_MULH   = 4'h1;
    localparam logic [3:0] OP_MULHSU = 4'h2;
    localparam logic [3:0] OP_MULHU  = 4'h3;
    localparam logic [3:0] OP_DIV    = 4'h4;
    localparam logic [3:0] OP_DIVU   = 4'h5;
    localparam logic [3:0] OP_REM    = 4'h6;
    localparam logic [3:0] OP_REMU   = 4'h7;
    localparam logic [3:0] OP_MULW   = 4'h8;
    localparam logic [3:0] OP_DIVW   = 4'hC;
    localparam logic [3:0] OP_DIVUW  = 4'hD;
    localparam logic [3:0] OP_REMW   = 4'hE;
    localparam logic [3:0] OP_REMUW  = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } mdu_state_e;

    function automatic logic is_illegal(input logic [3:0] op);
        logic r;
        case (op)
            4'h9, 4'hA, 4'hB: r = 1'b1;
            default:          r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return op[2];
    endfunction

    function automatic logic is_word(input logic [3:0] op);
        return op[3];
    endfunction

    function automatic logic wants_rem(input logic [3:0] op);
        return op[2] & op[1];
    endfunction

    function automatic logic wants_high(input logic [3:0] op);
        logic r;
        case (op)
            OP_MULH, OP_MULHSU, OP_MULHU: r = 1'b1;
            default:                      r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_signed_src1(input logic [3:0] op);
        logic r;
        case (op)
            OP_MULHU, OP_DIVU, OP_REMU, OP_DIVUW, OP_REMUW: r = 1'b0;
            default:                                        r = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic is_signed_src2(input logic [3:0] op);
        logic r;
        case (op)
            OP_MULHSU, OP_MULHU, OP_DIVU, OP_REMU, OP_DIVUW, OP_REMUW: r = 1'b0;
            default:                                                   r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ysyx_22050612_mdu_div.sv
// One restoring-division step on unsigned magnitudes: shift the partial
// remainder left, trial-subtract the divisor, restore on borrow.
module ysyx_22050612_mdu_div
    import ysyx_22050612_mdu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_nxt,
    output logic [XLEN-1:0] quo_nxt
);

    // Partial remainder is at most 2*divisor-1, so one extra bit suffices.
    logic [XLEN:0] shifted_s;
    logic [XLEN:0] trial_s;

    // Trial subtract and restore
    always_comb begin
        shifted_s = {rem, quo[XLEN-1]};
        trial_s   = shifted_s - {1'b0, divisor};
        if (trial_s[XLEN]) begin
            rem_nxt = shifted_s[XLEN-1:0];
            quo_nxt = {quo[XLEN-2:0], 1'b0};
        end else begin
            rem_nxt = trial_s[XLEN-1:0];
            quo_nxt = {quo[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/ysyx_22050612_mdu.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiplier and
// restoring divider behind a valid/ready handshake, result held until taken.
module ysyx_22050612_mdu
    import ysyx_22050612_mdu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam int DW = 2 * XLEN;

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] t;
        t       = {XLEN{v[31]}};
        t[31:0] = v[31:0];
        return t;
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] t;
        t       = {XLEN{1'b0}};
        t[31:0] = v[31:0];
        return t;
    endfunction

    mdu_state_e      state_r;
    logic [CW-1:0]   cnt_r;
    logic            out_valid_r;
    logic [XLEN-1:0] result_r;
    logic [3:0]      op_r;
    logic            word_r;
    logic            neg_r;
    logic [DW-1:0]   acc_r;
    logic [DW-1:0]   mcand_r;
    logic [XLEN-1:0] mplier_r;
    logic [XLEN-1:0] rem_r;
    logic [XLEN-1:0] quo_r;
    logic [XLEN-1:0] dvs_r;

    logic            word_s;
    logic            sgn1_s;
    logic            sgn2_s;
    logic [XLEN-1:0] a_ext_s;
    logic [XLEN-1:0] b_ext_s;
    logic            a_neg_s;
    logic            b_neg_s;
    logic [XLEN-1:0] mag_a_s;
    logic [XLEN-1:0] mag_b_s;
    logic [XLEN-1:0] min_s;
    logic            dz_s;
    logic            ovf_s;
    logic            neg_s;
    logic            bypass_s;
    logic [XLEN-1:0] spec_s;

    // Operand conditioning, sign tracking and divide special cases at acceptance
    always_comb begin
        word_s  = is_word(op) && (XLEN == 64);
        sgn1_s  = is_signed_src1(op);
        sgn2_s  = is_signed_src2(op);
        if (word_s) begin
            a_ext_s = sgn1_s ? sext32(src1) : zext32(src1);
            b_ext_s = sgn2_s ? sext32(src2) : zext32(src2);
        end else begin
            a_ext_s = src1;
            b_ext_s = src2;
        end
        a_neg_s = sgn1_s && a_ext_s[XLEN-1];
        b_neg_s = sgn2_s && b_ext_s[XLEN-1];
        mag_a_s = a_neg_s ? -a_ext_s : a_ext_s;
        mag_b_s = b_neg_s ? -b_ext_s : b_ext_s;
        neg_s   = wants_rem(op) ? a_neg_s : (a_neg_s ^ b_neg_s);

        min_s = {XLEN{1'b0}};
        if (word_s) begin
            min_s        = {XLEN{1'b1}};
            min_s[30:0]  = 31'd0;
        end else begin
            min_s[XLEN-1] = 1'b1;
        end
        dz_s     = (b_ext_s == {XLEN{1'b0}});
        ovf_s    = sgn1_s && sgn2_s && (a_ext_s == min_s) && (b_ext_s == {XLEN{1'b1}});
        bypass_s = is_illegal(op) || (is_div(op) && (dz_s || ovf_s));

        if (is_illegal(op)) begin
            spec_s = {XLEN{1'b0}};
        end else if (wants_rem(op)) begin
            spec_s = dz_s ? a_ext_s : {XLEN{1'b0}};
        end else begin
            spec_s = dz_s ? {XLEN{1'b1}} : a_ext_s;
        end
        if (word_s) begin
            spec_s = sext32(spec_s);
        end else begin
            spec_s = spec_s;
        end
    end

    logic [DW-1:0]   acc_nxt_s;
    logic [XLEN-1:0] rem_nxt_s;
    logic [XLEN-1:0] quo_nxt_s;
    logic [DW-1:0]   prod_s;
    logic [XLEN-1:0] raw_s;
    logic [XLEN-1:0] final_s;
    logic            last_s;

    ysyx_22050612_mdu_div #(.XLEN(XLEN)) u_div (
        .rem     (rem_r),
        .quo     (quo_r),
        .divisor (dvs_r),
        .rem_nxt (rem_nxt_s),
        .quo_nxt (quo_nxt_s)
    );

    // Multiply step and sign fix-up of the value the final CALC edge will produce
    always_comb begin
        acc_nxt_s = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
        prod_s    = neg_r ? -acc_nxt_s : acc_nxt_s;
        if (is_div(op_r)) begin
            if (wants_rem(op_r)) begin
                raw_s = neg_r ? -rem_nxt_s : rem_nxt_s;
            end else begin
                raw_s = neg_r ? -quo_nxt_s : quo_nxt_s;
            end
        end else if (wants_high(op_r)) begin
            raw_s = prod_s[DW-1:XLEN];
        end else begin
            raw_s = prod_s[XLEN-1:0];
        end
        final_s = word_r ? sext32(raw_s) : raw_s;
        last_s  = (cnt_r == (word_r ? CW'(31) : CW'(XLEN - 1)));
    end

    // Control FSM with datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            cnt_r       <= {CW{1'b0}};
            out_valid_r <= 1'b0;
            result_r    <= {XLEN{1'b0}};
            op_r        <= 4'h0;
            word_r      <= 1'b0;
            neg_r       <= 1'b0;
            acc_r       <= {DW{1'b0}};
            mcand_r     <= {DW{1'b0}};
            mplier_r    <= {XLEN{1'b0}};
            rem_r       <= {XLEN{1'b0}};
            quo_r       <= {XLEN{1'b0}};
            dvs_r       <= {XLEN{1'b0}};
        end else if (flush) begin
            state_r     <= S_IDLE;
            cnt_r       <= {CW{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid) begin
                        op_r     <= op;
                        word_r   <= word_s;
                        neg_r    <= neg_s;
                        cnt_r    <= {CW{1'b0}};
                        acc_r    <= {DW{1'b0}};
                        mcand_r  <= {{XLEN{1'b0}}, mag_a_s};
                        mplier_r <= mag_b_s;
                        rem_r    <= {XLEN{1'b0}};
                        // W dividends start in the upper half so 32 steps consume them
                        quo_r    <= word_s ? (mag_a_s << 32) : mag_a_s;
                        dvs_r    <= mag_b_s;
                        if (bypass_s) begin
                            state_r     <= S_DONE;
                            out_valid_r <= 1'b1;
                            result_r    <= spec_s;
                        end else begin
                            state_r <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_r    <= acc_nxt_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    rem_r    <= rem_nxt_s;
                    quo_r    <= quo_nxt_s;
                    cnt_r    <= cnt_r + CW'(1);
                    if (last_s) begin
                        state_r     <= S_DONE;
                        out_valid_r <= 1'b1;
                        result_r    <= final_s;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_r     <= S_IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= S_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == S_IDLE);
    assign out_valid = out_valid_r;
    assign result    = result_r;

endmodule

// File: tb/tb_ysyx_22050612_mdu.sv
// Directed self-checking bench for the iterative multiply/divide unit.
module tb_ysyx_22050612_mdu;
    import ysyx_22050612_mdu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [63:0] src1;
    logic [63:0] src2;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;

    int checks = 0;
    int errors = 0;

    ysyx_22050612_mdu #(.XLEN(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op for one edge, then scramble the inputs to prove latching
    task automatic issue(input string tag, input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
        chk({tag, "/in_ready"}, {63'd0, in_ready}, 64'd1);
        op = o; src1 = a; src2 = b; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        op   = 4'($urandom_range(0, 15));
        src1 = {$urandom(), $urandom()};
        src2 = {$urandom(), $urandom()};
    endtask

    task automatic wait_valid(input string tag, input int exp_edges);
        int edges;
        edges = 0;
        while (!out_valid && edges < 200) begin
            tick();
            edges++;
        end
        chk({tag, "/latency"}, 64'(edges), 64'(exp_edges));
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "/out_valid_drop"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "/in_ready_back"}, {63'd0, in_ready}, 64'd1);
    endtask

    task automatic do_op(input string tag, input logic [3:0] o, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp, input int edges);
        issue(tag, o, a, b);
        wait_valid(tag, edges);
        chk({tag, "/result"}, result, exp);
        release_out(tag);
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 4'h0; src1 = 64'd0; src2 = 64'd0;
        #12;
        chk("reset/in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset/out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset/result", result, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Multiplies
        do_op("mul_m1x5", OP_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'hFFFF_FFFF_FFFF_FFFB, 64);
        do_op("mulhu_max", OP_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_FFFF_FFFE, 64);
        do_op("mulhsu_m1x2", OP_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64);
        do_op("mulh_min_sq", OP_MULH, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
              64'h4000_0000_0000_0000, 64);
        do_op("mulw", OP_MULW, 64'hABCD_0000_7FFF_FFFF, 64'h1234_0000_0000_0002,
              64'hFFFF_FFFF_FFFF_FFFE, 32);

        // Divides
        do_op("div_m7_2", OP_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64);
        do_op("rem_m7_2", OP_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64);
        do_op("divu_max_3", OP_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555, 64);
        do_op("remu_100_7", OP_REMU, 64'd100, 64'd7, 64'd2, 64);
        do_op("divuw", OP_DIVUW, 64'hFFFF_FFFF_FFFF_FFF0, 64'h10, 64'h0000_0000_0FFF_FFFF, 32);
        do_op("remw_m7_2", OP_REMW, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 32);

        // Special cases and illegal codes take the one-cycle path
        do_op("divw_ovf", OP_DIVW, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
              64'hFFFF_FFFF_8000_0000, 0);
        do_op("div_ovf", OP_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h8000_0000_0000_0000, 0);
        do_op("rem_ovf", OP_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0);
        do_op("divu_by0", OP_DIVU, 64'h55, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        do_op("remu_by0", OP_REMU, 64'h1234, 64'd0, 64'h1234, 0);
        do_op("remw_by0", OP_REMW, 64'h0000_0000_8000_0001, 64'hFFFF_FFFF_0000_0000,
              64'hFFFF_FFFF_8000_0001, 0);
        do_op("illegal9", 4'h9, 64'd77, 64'd3, 64'd0, 0);

        // Output hold while the sink stalls
        issue("hold", OP_MUL, 64'd3, 64'd4);
        wait_valid("hold", 64);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold/result", result, 64'd12);
            chk("hold/out_valid", {63'd0, out_valid}, 64'd1);
            chk("hold/in_ready", {63'd0, in_ready}, 64'd0);
        end
        release_out("hold");

        // Flush in CALC with a competing in_valid
        issue("flush_calc", OP_DIV, 64'd100, 64'd7);
        repeat (19) tick();
        chk("flush_calc/in_ready_busy", {63'd0, in_ready}, 64'd0);
        flush = 1'b1; in_valid = 1'b1; op = OP_MUL; src1 = 64'd2; src2 = 64'd2;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_calc/out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_calc/in_ready", {63'd0, in_ready}, 64'd1);
        seen = 1'b0;
        repeat (70) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("flush_calc/no_result", {63'd0, seen}, 64'd0);

        // Flush in IDLE blocks acceptance
        flush = 1'b1; in_valid = 1'b1; op = OP_DIVU; src1 = 64'd9; src2 = 64'd0;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_idle/in_ready", {63'd0, in_ready}, 64'd1);
        chk("flush_idle/out_valid", {63'd0, out_valid}, 64'd0);

        // Flush in DONE discards the result
        issue("flush_done", OP_DIVU, 64'd5, 64'd0);
        wait_valid("flush_done", 0);
        chk("flush_done/result", result, 64'hFFFF_FFFF_FFFF_FFFF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_done/out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_done/in_ready", {63'd0, in_ready}, 64'd1);

        // Asynchronous reset mid-CALC
        issue("rst_calc", OP_MUL, 64'd3, 64'd5);
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_calc/out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_calc/result", result, 64'd0);
        chk("rst_calc/in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        rst_n = 1'b1;
        tick();
        do_op("after_rst", OP_MUL, 64'd6, 64'd7, 64'd42, 64);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
